// File: rtl/snn_img_loader_if.sv
// Handshake bundle between the UART receiver, snn_img_loader and snn_core.
// The master side is the surrounding system (UART rx plus snn_core); the slave side is the loader.
interface snn_img_loader_if;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       rx_clr_rdy;
    logic [9:0] addr_input_unit;
    logic       q_input;
    logic       start;
    logic       core_done;
    logic       busy;
    logic       ovr_err;
    logic       frame_abort;

    modport master (
        output rx_rdy, rx_data, addr_input_unit, core_done,
        input  rx_clr_rdy, q_input, start, busy, ovr_err, frame_abort
    );

    modport slave (
        input  rx_rdy, rx_data, addr_input_unit, core_done,
        output rx_clr_rdy, q_input, start, busy, ovr_err, frame_abort
    );
endinterface

// File: rtl/snn_img_loader.sv
// snn_img_loader: unpacks 98-byte UART frames into a 784x1 pixel RAM and serves it to snn_core.
// Define SNN_LOADER_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES idle cycles.
module snn_img_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    snn_img_loader_if.slave bus
);
    localparam int         NUM_BYTES = NUM_PIXELS / 8;
    localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

    if ((NUM_PIXELS % 8) != 0 || NUM_PIXELS > 1024 || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > 1_048_575) begin : g_param_check
        $error("snn_img_loader: unsupported NUM_PIXELS or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {LOAD, SHIFT, FIRE, WAIT_CORE} state_e;

    state_e     state_q, state_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       start_q, start_d;
    logic       busy_q, busy_d;
    logic       ovr_err_q, ovr_err_d;
    logic       q_input_q;
    logic       clr_req;
    logic       wr_en;
    logic [9:0] mem_addr;
    logic       ram [NUM_PIXELS];

`ifdef SNN_LOADER_TIMEOUT_EN
    // Registered pulse lands on idle cycle TIMEOUT_CYCLES, so decide one cycle earlier.
    localparam logic [19:0] IDLE_LAST = 20'(TIMEOUT_CYCLES - 2);
    logic [19:0] idle_q, idle_d;
    logic        frame_abort_q, frame_abort_d;
`endif

    assign mem_addr = (state_q == SHIFT) ? {byte_cnt_q, bit_cnt_q} : bus.addr_input_unit;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ovr_err_d  = ovr_err_q;
        start_d    = 1'b0;
        clr_req    = 1'b0;
        wr_en      = 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
        idle_d        = idle_q;
        frame_abort_d = 1'b0;
`endif
        unique case (state_q)
            LOAD: begin
                if (bus.rx_rdy) begin
                    clr_req   = 1'b1;
                    shift_d   = bus.rx_data;
                    ovr_err_d = 1'b0;
                    state_d   = SHIFT;
`ifdef SNN_LOADER_TIMEOUT_EN
                    idle_d    = '0;
`endif
                end
`ifdef SNN_LOADER_TIMEOUT_EN
                else if (byte_cnt_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        idle_d        = '0;
                        byte_cnt_d    = '0;
                        frame_abort_d = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
            end
            SHIFT: begin
                wr_en     = 1'b1;
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        start_d    = 1'b1;
                        state_d    = FIRE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = LOAD;
                    end
                end
            end
            FIRE: begin
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (bus.core_done) state_d = LOAD;
            end
        endcase
        // Bytes arriving while the core owns the RAM are acknowledged and discarded.
        if ((state_q == FIRE || state_q == WAIT_CORE) && bus.rx_rdy) begin
            clr_req   = 1'b1;
            ovr_err_d = 1'b1;
        end
        busy_d = (state_d == FIRE) || (state_d == WAIT_CORE);
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            ovr_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            ovr_err_q  <= ovr_err_d;
        end
    end

`ifdef SNN_LOADER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q        <= '0;
            frame_abort_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            frame_abort_q <= frame_abort_d;
        end
    end
    assign bus.frame_abort = frame_abort_q;
`else
    assign bus.frame_abort = 1'b0;
`endif

    // NOTE: the pixel RAM has no reset so it can map onto a RAM macro; only its read register resets.
    always_ff @(posedge clk) begin
        if (wr_en) ram[mem_addr] <= shift_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_input_q <= 1'b0;
        else        q_input_q <= ram[mem_addr];
    end

    assign bus.rx_clr_rdy = clr_req & rst_n;
    assign bus.q_input    = q_input_q;
    assign bus.start      = start_q;
    assign bus.busy       = busy_q;
    assign bus.ovr_err    = ovr_err_q;
endmodule
